shader_operand_arbiter: RTL and testbench
=========================================

// Module: shader_operand_arbiter
// PURPOSE
// - Round-robin arbiter sharing one shader operand channel (scalar a/b/c + packed vector a/b/c) among NUM_REQ producers.
// - Sits between the per-wavefront operand fetch units and the single shader ALU consumer port.
// - Registered output stage; full throughput (one grant per cycle) when the consumer is always ready.
// PARAMETERS
// - WIDTH    32  scalar lane width in bits
// - LANES    4   vector lanes; VEC_W = WIDTH*LANES
// - NUM_REQ  4   number of requesters, 2..16; IDW = $clog2(NUM_REQ)
// - OPW      derived = 3*WIDTH + 3*VEC_W; bundle {a_s,b_s,c_s,a_v,b_v,c_v}, a_s in MSBs
// PORTS
// - clk           in   1            clock, all state on posedge
// - rst_n         in   1            asynchronous active-low reset
// - arb_en        in   1            1 = new grants allowed; 0 = freeze grants, drain the output register
// - req_valid     in   NUM_REQ      requester i has a bundle
// - req_ready     out  NUM_REQ      one-hot (or zero) accept to requester i
// - req_data      in   NUM_REQ*OPW  bundle i at [i*OPW +: OPW]
// - out_valid     out  1            consumer bundle valid (registered)
// - out_ready     in   1            consumer accept
// - out_data      out  OPW          granted bundle (registered)
// - out_src       out  IDW          index of the requester that sourced out_data
// BEHAVIOUR
// - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr_ptr=0; req_ready=0 while rst_n=0.
// - States: EMPTY (out_valid=0), FULL (out_valid=1). load = arb_en && |req_valid && (EMPTY || out_ready).
// - EMPTY->FULL on load. FULL->EMPTY on out_ready && !load. FULL->FULL on out_ready && load (back-to-back).
// - FULL && !out_ready: out_valid, out_data and out_src held stable; req_ready=0.
// - Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ (wraps NUM_REQ-1 -> 0).
// - req_ready is combinational: req_ready[g]=load, all other bits 0. No combinational path from req_data.
// - On load: out_data <= bundle g, out_src <= g, out_valid <= 1, rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1.
// - rr_ptr changes only on load. Latency: req accepted in cycle N -> out_valid=1 in cycle N+1.
// - A requester may drop req_valid without a handshake; no grant is issued to it and rr_ptr is unchanged.
// - arb_en=0: load=0; the bundle in FULL still completes its handshake; rr_ptr is frozen.
// - Starvation bound: a continuously valid requester is granted within NUM_REQ loads.
// - Reset mid-transfer: the held bundle is discarded and out_valid drops asynchronously; no replay.
// CONFIGURATION
// - SHADER_ARB_STATS_EN defined: add port grant_cnt out NUM_REQ*16. Counter i (16-bit, saturating at 16'hFFFF)
//   increments on each load with g==i; reset to 0; bits [i*16 +: 16].
// - SHADER_ARB_STATS_EN undefined: no counters; the grant_cnt port does not exist.
// TESTING
// - Single requester: req_valid=4'b0100, out_ready=1 -> req_ready=4'b0100 the same cycle; next cycle out_valid=1, out_src=2, rr_ptr=3.
// - All valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; one output per cycle.
// - Backpressure: FULL with out_src=1, out_ready=0 for 5 cycles -> out_data stable, req_ready=0; out_ready=1 -> next grant is 2.
// - Wrap: rr_ptr=3, req_valid=4'b0011 -> grant 0, rr_ptr=1.
// - arb_en=0 while FULL, out_ready=1 -> one beat delivered, then out_valid=0; no req_ready until arb_en=1.
// - rst_n low while FULL -> out_valid=0 immediately; after release, first grant starts from 0; STATS_EN: counters read 0.

Source files
------------

// File: rtl/shader_operand_arbiter.sv
// shader_operand_arbiter
//
// Round-robin arbiter that lets NUM_REQ operand fetch units share the single
// operand channel of the shader ALU. Each bundle is
// {a_s, b_s, c_s, a_v, b_v, c_v}, with a_s in the MSBs. The output stage is
// registered, so a bundle accepted in cycle N is presented in cycle N+1. When
// the consumer is always ready, the arbiter issues one grant per cycle.
//
// Ports
//   clk        clock; all state changes on posedge
//   rst_n      asynchronous active-low reset (release is synchronous upstream)
//   arb_en     1 = new grants allowed; 0 = no new grants, the output drains
//   req_valid  per-requester bundle valid
//   req_ready  one-hot (or zero) accept, combinational
//   req_data   bundle i at [i*OPW +: OPW]
//   out_valid  registered consumer valid
//   out_ready  consumer accept
//   out_data   registered granted bundle
//   out_src    index of the requester that sourced out_data
//   grant_cnt  (only with SHADER_ARB_STATS_EN) 16-bit saturating grant count
//              per requester, counter i at [i*16 +: 16]
//
// Optional feature macro: SHADER_ARB_STATS_EN

module shader_operand_arbiter #(
    parameter  int WIDTH   = 32,
    parameter  int LANES   = 4,
    parameter  int NUM_REQ = 4,
    localparam int VEC_W   = WIDTH * LANES,
    localparam int OPW     = 3 * WIDTH + 3 * VEC_W,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arb_en,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OPW-1:0]   req_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPW-1:0]           out_data,
    output logic [IDW-1:0]           out_src
`ifdef SHADER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [IDW:0]   REQ_CNT = (IDW + 1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    logic [0:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] next_ptr;
    logic [IDW:0]   idx;
    logic           found;
    logic           load;

    assign out_valid = (state == ST_FULL);

    // Scan from rr_ptr upward, wrapping at NUM_REQ, and take the first valid.
    // idx carries one extra bit so the wrap also works when NUM_REQ is not a
    // power of two.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (idx >= REQ_CNT) begin
                idx = idx - REQ_CNT;
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    // The output register may be refilled when it is empty, or in the same
    // cycle that the consumer takes the current bundle.
    assign load = arb_en && (|req_valid) && (!out_valid || out_ready);

    assign next_ptr = (grant == LAST_ID) ? '0 : grant + IDW'(1);

    // req_ready is forced low while reset is asserted. The state registers use
    // the ungated load, because reset overrides them anyway.
    always_comb begin
        req_ready = '0;
        if (load && rst_n) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            state    <= ST_FULL;
            out_data <= req_data[grant*OPW +: OPW];
            out_src  <= grant;
            rr_ptr   <= next_ptr;
        end else if (out_valid && out_ready) begin
            state    <= ST_EMPTY;
        end
    end

`ifdef SHADER_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (load && (cnt[grant] != 16'hFFFF)) begin
            cnt[grant] <= cnt[grant] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        assign grant_cnt[gi*16 +: 16] = cnt[gi];
    end
`endif

endmodule

// File: tb/tb_shader_operand_arbiter.sv
// tb_shader_operand_arbiter
//
// Directed bench for shader_operand_arbiter with WIDTH=32, LANES=4 and
// NUM_REQ=4. Every requester presents a distinct bundle that is built from
// (requester index, tag), so the bench can tell which bundle reached out_data.

module tb_shader_operand_arbiter;

    localparam int WIDTH   = 32;
    localparam int LANES   = 4;
    localparam int NUM_REQ = 4;
    localparam int OPW     = 3 * WIDTH + 3 * WIDTH * LANES;
    localparam int IDW     = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   arb_en;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*OPW-1:0] req_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [OPW-1:0]         out_data;
    logic [IDW-1:0]         out_src;
`ifdef SHADER_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]  grant_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int tag   = 0;

    shader_operand_arbiter #(
        .WIDTH(WIDTH), .LANES(LANES), .NUM_REQ(NUM_REQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
`ifdef SHADER_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OPW-1:0] mk(int i, int t);
        logic [OPW-1:0] v;
        v = '0;
        for (int w = 0; w < OPW / 32; w++) begin
            v[w*32 +: 32] = {8'(t), 8'(i), 8'(w), 8'(t ^ (i * 17) ^ w)};
        end
        return v;
    endfunction

    task automatic set_data(int t);
        tag = t;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*OPW +: OPW] = mk(i, t);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; arb_en = 1'b1; out_ready = 1'b1; req_valid = 4'hF;
        set_data(1);
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_data got %h want 0", out_data[31:0]); end
        n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL rst_src got %0d want 0", out_src); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got %b want 0000", req_ready); end
`ifdef SHADER_ARB_STATS_EN
        n_cmp++; if (grant_cnt !== '0) begin n_bad++; $display("FAIL rst_cnt got %h want 0", grant_cnt); end
`endif
        req_valid = 4'h0;
        rst_n = 1'b1;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rel_valid got %b want 0", out_valid); end
    endtask

    task automatic test_single;
        set_data(2);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
        tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if (out_src !== 2'd2) begin n_bad++; $display("FAIL single_src got %0d want 2", out_src); end
        n_cmp++; if (out_data !== mk(2, 2)) begin n_bad++; $display("FAIL single_data got %h want %h", out_data[31:0], mk(2, 2) & 32'hFFFFFFFF); end
        // rr_ptr is now 3, so the next grant among all-valid requesters is 3
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL single_ptr3 got %b want 1000", req_ready); end
        tick;
        n_cmp++; if (out_src !== 2'd3) begin n_bad++; $display("FAIL single_src3 got %0d want 3", out_src); end
        req_valid = 4'b0000;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin;
        set_data(3);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (req_ready !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
            tick;
            n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_src[%0d] got v=%b src=%0d want v=1 src=%0d", k, out_valid, out_src, k % 4); end
            n_cmp++; if (out_data !== mk(k % 4, 3)) begin n_bad++; $display("FAIL rr_data[%0d] got %h want %h", k, out_data[31:0], mk(k % 4, 3) & 32'hFFFFFFFF); end
        end
        req_valid = 4'b0000;
        tick;
    endtask

    task automatic test_backpressure;
        set_data(4);
        req_valid = 4'b0010;
        tick;
        n_cmp++; if (out_src !== 2'd1) begin n_bad++; $display("FAIL bp_fill got %0d want 1", out_src); end
        out_ready = 1'b0;
        req_valid = 4'b1111;
        set_data(5);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d] got %b want 0000", k, req_ready); end
            tick;
            n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== mk(1, 4)) begin
                n_bad++; $display("FAIL bp_hold[%0d] got v=%b src=%0d d=%h want v=1 src=1 d=%h", k, out_valid, out_src, out_data[31:0], mk(1, 4) & 32'hFFFFFFFF);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_release got %b want 0100", req_ready); end
        tick;
        n_cmp++; if (out_src !== 2'd2 || out_data !== mk(2, 5)) begin n_bad++; $display("FAIL bp_next got %0d want 2", out_src); end
        req_valid = 4'b0000;
        tick;
    endtask

    task automatic test_wrap;
        // rr_ptr is 3 here
        req_valid = 4'b0011;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_ready got %b want 0001", req_ready); end
        tick;
        n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL wrap_src got %0d want 0", out_src); end
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_ptr1 got %b want 0010", req_ready); end
        tick;
        n_cmp++; if (out_src !== 2'd1) begin n_bad++; $display("FAIL wrap_src1 got %0d want 1", out_src); end
        req_valid = 4'b0000;
        tick;
    endtask

    task automatic test_arb_en;
        // rr_ptr is 2 here
        req_valid = 4'b0100;
        tick;
        n_cmp++; if (out_src !== 2'd2 || out_valid !== 1'b1) begin n_bad++; $display("FAIL en_fill got src=%0d v=%b want 2/1", out_src, out_valid); end
        arb_en = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL en_off_ready got %b want 0000", req_ready); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL en_drain got %b want 0", out_valid); end
        tick;
        n_cmp++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL en_idle got v=%b r=%b want 0/0000", out_valid, req_ready); end
        arb_en = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL en_resume got %b want 1000", req_ready); end
        tick;
        n_cmp++; if (out_src !== 2'd3) begin n_bad++; $display("FAIL en_src got %0d want 3", out_src); end
    endtask

    task automatic test_drop;
        // FULL with out_src=3, rr_ptr=0
        out_ready = 1'b0;
        req_valid = 4'b0001;
        tick;
        n_cmp++; if (out_src !== 2'd3 || out_valid !== 1'b1) begin n_bad++; $display("FAIL drop_hold got src=%0d want 3", out_src); end
        req_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL drop_ready got %b want 0100", req_ready); end
        tick;
        n_cmp++; if (out_src !== 2'd2) begin n_bad++; $display("FAIL drop_src got %0d want 2", out_src); end
    endtask

    task automatic test_reset_mid;
        // FULL with out_src=2, rr_ptr=3
        out_ready = 1'b0;
        req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0 || out_src !== 2'd0) begin n_bad++; $display("FAIL mid_clear got src=%0d want 0", out_src); end
`ifdef SHADER_ARB_STATS_EN
        n_cmp++; if (grant_cnt !== '0) begin n_bad++; $display("FAIL mid_cnt got %h want 0", grant_cnt); end
`endif
        tick;
        rst_n = 1'b1;
        tick;
        set_data(6);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first got %b want 0001", req_ready); end
        tick;
        n_cmp++; if (out_src !== 2'd0 || out_data !== mk(0, 6)) begin n_bad++; $display("FAIL mid_src got %0d want 0", out_src); end
`ifdef SHADER_ARB_STATS_EN
        n_cmp++; if (grant_cnt !== 64'h0000_0000_0000_0001) begin n_bad++; $display("FAIL mid_cnt1 got %h want 1", grant_cnt); end
`endif
        req_valid = 4'b0000;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_wrap;
        test_arb_en;
        test_drop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
